// File: rtl/adder_result_checker_if.sv
// Vector handshake carrying one adder stimulus/response pair per transfer
// from the stimulus side (master) to the result checker (slave).
interface adder_result_checker_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;
    logic             dut_of;

    modport master (
        output in_valid, a, b, cin, dut_sum, dut_cout, dut_of,
        input  in_ready
    );

    modport slave (
        input  in_valid, a, b, cin, dut_sum, dut_cout, dut_of,
        output in_ready
    );
endinterface

// File: rtl/adder_result_checker.sv
// Adder result checker: recomputes a + b + cin for every accepted vector,
// compares sum / carry-out / signed overflow against the adder under test and
// keeps pass/fail statistics for a programmed run length.
// Two-stage pipeline: stage 1 registers the vector, stage 2 registers the
// compare result, and the counters update from stage 2.
// Optional feature: define HALT_ON_FAIL_EN to stop accepting vectors after the
// first mismatch (the vector already in stage 1 is still counted).
module adder_result_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_vec,
    adder_result_checker_if.slave vec,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [CNT_W-1:0]      first_fail_idx,
    output logic                  first_fail_vld
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             of;
        logic [CNT_W-1:0] idx;
    } vec_t;

    state_t           state;
    logic [CNT_W-1:0] num_vec_q;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] acc_nxt;
    logic [STAGES:1]  vld_pipe;
    vec_t             s1;
    logic             s2_match;
    logic [CNT_W-1:0] s2_idx;
    logic [WIDTH:0]   g;
    logic             g_of;
    logic             match;
    logic             xfer;
    logic             halt_now;

    // Golden result on the stage-1 vector, one bit wider to keep the carry.
    assign g     = {1'b0, s1.a} + {1'b0, s1.b} + {{WIDTH{1'b0}}, s1.cin};
    assign g_of  = (s1.a[WIDTH-1] == s1.b[WIDTH-1]) && (g[WIDTH-1] != s1.a[WIDTH-1]);
    assign match = (s1.sum == g[WIDTH-1:0]) && (s1.cout == g[WIDTH]) && (s1.of == g_of);

`ifdef HALT_ON_FAIL_EN
    // A mismatch leaving stage 2 closes the input in the same cycle.
    assign halt_now = vld_pipe[2] && !s2_match;
`else
    assign halt_now = 1'b0;
`endif

    assign vec.in_ready = (state == RUN) && (accepted < num_vec_q) && !halt_now;
    assign xfer         = vec.in_valid && vec.in_ready;
    assign acc_nxt      = accepted + {{(CNT_W-1){1'b0}}, xfer};

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (fail_cnt == '0);

    // Pipeline valid shift register; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
    end

    // Pipeline data: capture on transfer, compare one cycle later.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1 <= '{a: vec.a, b: vec.b, cin: vec.cin, sum: vec.dut_sum,
                    cout: vec.dut_cout, of: vec.dut_of, idx: accepted};
        end
        if (vld_pipe[1]) begin
            s2_match <= match;
            s2_idx   <= s1.idx;
        end
    end

    // Run control FSM with statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            num_vec_q      <= '0;
            accepted       <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            if (vld_pipe[2]) begin
                if (s2_match) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= s2_idx;
                    end
                end
            end
            if (xfer) accepted <= acc_nxt;
            case (state)
                IDLE, DONE: begin
                    // Pipeline is empty here, so clearing cannot race a count.
                    if (start) begin
                        num_vec_q      <= num_vec;
                        accepted       <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                        state          <= (num_vec == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (halt_now || (acc_nxt == num_vec_q)) state <= DRAIN;
                end
                DRAIN: begin
                    // Stage 2 retires on this edge; only stage 1 must be empty.
                    if (!vld_pipe[1]) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized bench for adder_result_checker with an arithmetic reference model.
module tb_adder_result_checker;
    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_vec;
    logic          busy, done, pass, first_fail_vld;
    logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [W-1:0] va[$], vb[$], ds[$];
    logic         vc[$], dco[$], dof[$];

    adder_result_checker_if #(.WIDTH(W)) vif ();

    adder_result_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .vec(vif.slave),
        .busy(busy), .done(done), .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic, signed range test for overflow.
    function automatic void golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                   output logic [W-1:0] s, output logic co, output logic of);
        longint u, sa, sb, ss;
        u  = longint'(a) + longint'(b) + longint'(c);
        sa = $signed(a);
        sb = $signed(b);
        ss = sa + sb + longint'(c);
        s  = u[W-1:0];
        co = u[W];
        of = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    endfunction

    task automatic clr();
        va.delete(); vb.delete(); vc.delete(); ds.delete(); dco.delete(); dof.delete();
    endtask

    task automatic push_raw(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic [W-1:0] s, input logic co, input logic of);
        va.push_back(a); vb.push_back(b); vc.push_back(c);
        ds.push_back(s); dco.push_back(co); dof.push_back(of);
    endtask

    // bad: 0 correct, 1 one sum bit flipped, 2 cout flipped, 3 of flipped
    task automatic push_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int bad);
        logic [W-1:0] s;
        logic co, of;
        golden(a, b, c, s, co, of);
        if (bad == 1) s  = s ^ (32'h1 << $urandom_range(0, W-1));
        if (bad == 2) co = ~co;
        if (bad == 3) of = ~of;
        push_raw(a, b, c, s, co, of);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
        check({tag, "_ff_idx"}, first_fail_idx, 0);
        check({tag, "_ff_vld"}, first_fail_vld, 0);
        check({tag, "_in_ready"}, vif.in_ready, 0);
    endtask

    // vmode: 0 random gaps, 1 alternate valid, 2 always valid.
    // abort_after > 0 asserts rst once that many transfers have occurred.
    task automatic run(input int n, input int vmode, input int abort_after, input bit poke, input string tag);
        int idx = 0, last_x = -1, done_cyc = -1, start_cyc, exp_p = 0, exp_f = 0, ff = -1, fb = -1;
        bit extra_rdy = 0, vld, halt;
        logic [W-1:0] gs;
        logic gco, gof;
        @(negedge clk); start = 1; num_vec = CW'(n); start_cyc = cyc;
        @(negedge clk); start = 0; num_vec = CW'($urandom);
        for (int k = 0; k < 400; k++) begin
            if (done) begin done_cyc = cyc; break; end
            start   = poke && (idx == 1);
            num_vec = CW'($urandom);
            case (vmode)
                1:       vld = (k % 2 == 0);
                2:       vld = 1'b1;
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            if (vld && idx < n) begin
                vif.in_valid = 1; vif.a = va[idx]; vif.b = vb[idx]; vif.cin = vc[idx];
                vif.dut_sum = ds[idx]; vif.dut_cout = dco[idx]; vif.dut_of = dof[idx];
            end else begin
                vif.in_valid = 0; vif.a = $urandom; vif.b = $urandom; vif.cin = 1'($urandom);
                vif.dut_sum = $urandom; vif.dut_cout = 1'($urandom); vif.dut_of = 1'($urandom);
            end
            #1;
            if (idx >= n && vif.in_ready) extra_rdy = 1;
            if (vif.in_valid && vif.in_ready) begin
                idx++;
                last_x = cyc + 1;
                if (idx == abort_after) begin
                    @(negedge clk); vif.in_valid = 0; start = 0; rst = 1;
                    @(negedge clk); check_idle({tag, "_inrst"});
                    rst = 0;
                    repeat (3) @(negedge clk);
                    check_idle({tag, "_postrst"});
                    return;
                end
            end
            @(negedge clk);
        end
        vif.in_valid = 0;
        start = 0;
        check({tag, "_done"}, done, 1);
        for (int i = 0; i < n; i++) begin
            golden(va[i], vb[i], vc[i], gs, gco, gof);
            if (!(gs == ds[i] && gco == dco[i] && gof == dof[i]) && fb < 0) fb = i;
        end
        for (int i = 0; i < idx; i++) begin
            golden(va[i], vb[i], vc[i], gs, gco, gof);
            if (gs == ds[i] && gco == dco[i] && gof == dof[i]) exp_p++;
            else begin exp_f++; if (ff < 0) ff = i; end
        end
`ifdef HALT_ON_FAIL_EN
        halt = (fb >= 0);
`else
        halt = 1'b0;
`endif
        if (halt) check({tag, "_nxfer_bound"}, (idx <= fb + 2) && (idx >= fb + 1), 1);
        else      check({tag, "_nxfer"}, idx, n);
        check({tag, "_pass_cnt"}, pass_cnt, exp_p);
        check({tag, "_fail_cnt"}, fail_cnt, exp_f);
        check({tag, "_ff_vld"}, first_fail_vld, exp_f > 0);
        if (ff >= 0) check({tag, "_ff_idx"}, first_fail_idx, ff);
        check({tag, "_pass"}, pass, exp_f == 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready_after_last"}, extra_rdy, 0);
        check({tag, "_ready_in_done"}, vif.in_ready, 0);
        if (n == 0)     check({tag, "_lat0"}, done_cyc - start_cyc, 1);
        else if (!halt) check({tag, "_lat"}, done_cyc - last_x, 2);
        repeat (2) @(negedge clk);
        check({tag, "_done_hold"}, done, 1);
        check({tag, "_cnt_hold"}, pass_cnt + fail_cnt, exp_p + exp_f);
    endtask

    initial begin
        int n, bad;
        rst = 1; start = 0; num_vec = '0;
        vif.in_valid = 0; vif.a = '0; vif.b = '0; vif.cin = 0;
        vif.dut_sum = '0; vif.dut_cout = 0; vif.dut_of = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 0;

        // Signed corner vectors from a correct adder.
        clr();
        push_raw(32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1);
        push_raw(32'hFFFFFFFF, 32'h80000000, 0, 32'h7FFFFFFF, 1, 1);
        push_raw(32'h7FFFFFFF, 32'hFFFFFFFF, 0, 32'h7FFFFFFE, 1, 0);
        push_raw(32'h00000001, 32'h80000000, 0, 32'h80000001, 0, 0);
        push_raw(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 1, 0);
        run(5, 2, 0, 0, "t1");

        // Vector 2 has overflow flipped; start pulsed mid-run must be ignored.
        clr();
        for (int i = 0; i < 4; i++) push_vec($urandom, $urandom, 1'($urandom), (i == 2) ? 3 : 0);
        run(4, 0, 0, 1, "t2");

        // Empty run.
        clr();
        run(0, 0, 0, 0, "t3");

        // Alternating valid.
        clr();
        for (int i = 0; i < 3; i++) push_vec($urandom, $urandom, 1'($urandom), 0);
        run(3, 1, 0, 0, "t4");

        // Reset mid-run, then a clean re-run.
        clr();
        for (int i = 0; i < 5; i++) push_vec($urandom, $urandom, 1'($urandom), (i == 1) ? 2 : 0);
        run(5, 2, 2, 0, "t5_abort");
        run(5, 0, 0, 0, "t5_rerun");

        // Early failure with back-to-back traffic.
        clr();
        for (int i = 0; i < 6; i++) push_vec($urandom, $urandom, 1'($urandom), (i == 1) ? 1 : 0);
        run(6, 2, 0, 0, "t6");

        // Random runs with mixed fault types.
        for (int r = 0; r < 8; r++) begin
            clr();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                push_vec($urandom, $urandom, 1'($urandom), bad);
            end
            run(n, r % 3, 0, (r % 2 == 1) && (n > 3), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
